// File: rtl/mac_accumulator_controller.sv
// +------------------------------------------------------------------------------+
// | mac_accumulator_controller: streams (input, weight) pairs into an external     |
// | combinational MAC and returns the finished dot product on a valid/ready port.  |
// | Revision: 1.0                                                                  |
// +------------------------------------------------------------------------------+
`default_nettype none

module mac_accumulator_controller #(
  parameter int DATA_WIDTH    = 8,
  parameter int VECTOR_LENGTH = 4,
  parameter int COUNT_WIDTH   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic [DATA_WIDTH-1:0]   in_weight,
  output logic [2*DATA_WIDTH-1:0] mac_add_value,
  output logic [DATA_WIDTH-1:0]   mac_input_value,
  output logic [DATA_WIDTH-1:0]   mac_weight_value,
  input  logic [2*DATA_WIDTH-1:0] mac_output_value,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*DATA_WIDTH-1:0] out_data,
  output logic                    busy
);

  localparam logic [COUNT_WIDTH-1:0] LAST_INDEX = COUNT_WIDTH'(VECTOR_LENGTH - 1);

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [2*DATA_WIDTH-1:0] acc;
  logic [COUNT_WIDTH-1:0]  count;
  logic                    accept;
  logic                    last_pair;

  // The MAC sees the operands every cycle; acc only moves on an accepted pair.
  assign mac_add_value    = acc;
  assign mac_input_value  = in_data;
  assign mac_weight_value = in_weight;

  assign accept    = in_valid && in_ready;
  assign last_pair = (count == LAST_INDEX);
  assign busy      = (count != '0) || (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACCUM;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    unique case (state)
      ACCUM: begin
        in_ready = 1'b1;
        if (!clear && accept && last_pair) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (clear || out_ready) begin
          state_next = ACCUM;
        end
      end
      default: state_next = ACCUM;
    endcase
  end

  // Clear takes priority over a same-cycle accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      count    <= '0;
      out_data <= '0;
    end else if (clear) begin
      acc   <= '0;
      count <= '0;
    end else if (accept) begin
      if (last_pair) begin
        out_data <= mac_output_value;
        acc      <= '0;
        count    <= '0;
      end else begin
        acc   <= mac_output_value;
        count <= count + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mac_accumulator_controller.sv
// +------------------------------------------------------------------------------+
// | tb_mac_accumulator_controller: directed bench for three controller instances   |
// | (VECTOR_LENGTH 4, 2, 1), each closed around a behavioural MAC.                 |
// | Revision: 1.0                                                                  |
// +------------------------------------------------------------------------------+
`default_nettype none

module tb_mac_accumulator_controller;

  localparam int DW = 8;
  localparam int NI = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear     [NI];
  logic          in_valid  [NI];
  logic          in_ready  [NI];
  logic [DW-1:0] in_data   [NI];
  logic [DW-1:0] in_weight [NI];
  logic [2*DW-1:0] mac_add [NI];
  logic [DW-1:0]   mac_in  [NI];
  logic [DW-1:0]   mac_w   [NI];
  logic [2*DW-1:0] mac_out [NI];
  logic            out_valid [NI];
  logic            out_ready [NI];
  logic [2*DW-1:0] out_data  [NI];
  logic            busy      [NI];

  int n_compared   = 0;
  int n_mismatched = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int VL = (g == 0) ? 4 : (g == 1) ? 2 : 1;

    assign mac_out[g] = mac_add[g] + ({8'd0, mac_in[g]} * {8'd0, mac_w[g]});

    mac_accumulator_controller #(
      .DATA_WIDTH   (DW),
      .VECTOR_LENGTH(VL),
      .COUNT_WIDTH  (8)
    ) u_dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .clear           (clear[g]),
      .in_valid        (in_valid[g]),
      .in_ready        (in_ready[g]),
      .in_data         (in_data[g]),
      .in_weight       (in_weight[g]),
      .mac_add_value   (mac_add[g]),
      .mac_input_value (mac_in[g]),
      .mac_weight_value(mac_w[g]),
      .mac_output_value(mac_out[g]),
      .out_valid       (out_valid[g]),
      .out_ready       (out_ready[g]),
      .out_data        (out_data[g]),
      .busy            (busy[g])
    );
  end

  task automatic check_value(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int k, input logic [DW-1:0] d, input logic [DW-1:0] w);
    in_valid[k]  = 1'b1;
    in_data[k]   = d;
    in_weight[k] = w;
    step();
    in_valid[k]  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < NI; k++) begin
      clear[k] = 1'b0; in_valid[k] = 1'b0; out_ready[k] = 1'b0;
      in_data[k] = '0; in_weight[k] = '0;
    end
    step();
    check_value("rst_out_valid", 32'(out_valid[0]), 0);
    check_value("rst_out_data",  32'(out_data[0]), 0);
    check_value("rst_busy",      32'(busy[0]), 0);
    check_value("rst_acc",       32'(mac_add[0]), 0);
    rst_n = 1'b1;

    // Vector (2,3),(5,2),(1,1),(255,255) -> 6+10+1+65025
    send(0, 2, 3);
    send(0, 5, 2);
    check_value("v1_busy_mid", 32'(busy[0]), 1);
    check_value("v1_acc_mid",  32'(mac_add[0]), 16);
    send(0, 1, 1);
    check_value("v1_no_early_valid", 32'(out_valid[0]), 0);
    send(0, 255, 255);
    check_value("v1_out_valid", 32'(out_valid[0]), 1);
    check_value("v1_out_data",  32'(out_data[0]), 65042);
    check_value("v1_in_ready",  32'(in_ready[0]), 0);
    check_value("v1_acc_reset", 32'(mac_add[0]), 0);

    // Backpressure with upstream valid held
    in_valid[0] = 1'b1; in_data[0] = 9; in_weight[0] = 9;
    for (int i = 0; i < 5; i++) begin
      step();
      check_value("bp_out_data",  32'(out_data[0]), 65042);
      check_value("bp_out_valid", 32'(out_valid[0]), 1);
      check_value("bp_in_ready",  32'(in_ready[0]), 0);
    end
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    step();
    check_value("bp_release_valid", 32'(out_valid[0]), 0);
    check_value("bp_release_ready", 32'(in_ready[0]), 1);
    check_value("bp_release_busy",  32'(busy[0]), 0);
    check_value("bp_release_acc",   32'(mac_add[0]), 0);
    for (int i = 0; i < 4; i++) send(0, 1, 2);
    check_value("v2_out_valid", 32'(out_valid[0]), 1);
    check_value("v2_out_data",  32'(out_data[0]), 8);
    step();
    check_value("v2_accepted", 32'(out_valid[0]), 0);

    // Idle X operands must not disturb acc, then asynchronous reset mid-cycle
    send(0, 4, 4);
    send(0, 4, 4);
    in_data[0] = 'x; in_weight[0] = 'x;
    step();
    check_value("x_idle_acc",  32'(mac_add[0]), 32);
    check_value("x_idle_busy", 32'(busy[0]), 1);
    #3;
    rst_n = 1'b0;
    #1;
    check_value("arst_busy",      32'(busy[0]), 0);
    check_value("arst_out_valid", 32'(out_valid[0]), 0);
    check_value("arst_acc",       32'(mac_add[0]), 0);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) send(0, 1, 1);
    check_value("arst_v_valid", 32'(out_valid[0]), 1);
    check_value("arst_v_data",  32'(out_data[0]), 4);
    step();

    // Clear in ACCUM beats a same-cycle valid pair
    for (int i = 0; i < 3; i++) send(0, 3, 3);
    check_value("clr_pre_acc", 32'(mac_add[0]), 27);
    clear[0] = 1'b1;
    send(0, 3, 3);
    clear[0] = 1'b0;
    check_value("clr_acc",       32'(mac_add[0]), 0);
    check_value("clr_busy",      32'(busy[0]), 0);
    check_value("clr_out_valid", 32'(out_valid[0]), 0);
    for (int i = 0; i < 4; i++) send(0, 2, 2);
    check_value("clr_v_data", 32'(out_data[0]), 16);
    step();

    // Clear in DONE drops the pending result
    out_ready[0] = 1'b0;
    for (int i = 0; i < 4; i++) send(0, 1, 1);
    step();
    check_value("clr_done_hold", 32'(out_valid[0]), 1);
    clear[0] = 1'b1;
    step();
    clear[0] = 1'b0;
    check_value("clr_done_valid", 32'(out_valid[0]), 0);
    check_value("clr_done_busy",  32'(busy[0]), 0);
    check_value("clr_done_ready", 32'(in_ready[0]), 1);

    // VECTOR_LENGTH=2 wrap-around: 2*65025 mod 65536
    out_ready[1] = 1'b1;
    send(1, 255, 255);
    check_value("vl2_mid_valid", 32'(out_valid[1]), 0);
    send(1, 255, 255);
    check_value("vl2_valid", 32'(out_valid[1]), 1);
    check_value("vl2_data",  32'(out_data[1]), 64514);

    // VECTOR_LENGTH=1: each accept completes a result
    out_ready[2] = 1'b1;
    send(2, 7, 9);
    check_value("vl1_a_valid", 32'(out_valid[2]), 1);
    check_value("vl1_a_data",  32'(out_data[2]), 63);
    check_value("vl1_a_ready", 32'(in_ready[2]), 0);
    step();
    check_value("vl1_gap_valid", 32'(out_valid[2]), 0);
    send(2, 10, 10);
    check_value("vl1_b_valid", 32'(out_valid[2]), 1);
    check_value("vl1_b_data",  32'(out_data[2]), 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mac_accumulator_controller.md
Name: mac_accumulator_controller

Overview:
- Sequential wrapper directly around one combinational multiply_and_add instance (output = add_value + input_value*weight_value).
- Streams VECTOR_LENGTH (input, weight) pairs in via valid/ready and feeds each pair to the MAC.
- Feeds its partial-sum register back as add_value; captures the MAC output every accepted cycle.
- Emits the finished dot product on a valid/ready output port. The MAC instance is external; this block only drives and samples its ports.

Parameters:
- DATA_WIDTH, 8: width of input and weight operands; sums are 2*DATA_WIDTH.
- VECTOR_LENGTH, 4: number of pairs per dot product; legal range 1..255.
- COUNT_WIDTH, 8: element counter width; must satisfy 2^COUNT_WIDTH > VECTOR_LENGTH.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous abort: discard partial sum and restart.
- in_valid  in  1  input pair valid.
- in_ready  out  1  block can accept a pair this cycle.
- in_data  in  DATA_WIDTH  input operand, unsigned.
- in_weight  in  DATA_WIDTH  weight operand, unsigned.
- mac_add_value  out  2*DATA_WIDTH  to MAC add_value.
- mac_input_value  out  DATA_WIDTH  to MAC input_value.
- mac_weight_value  out  DATA_WIDTH  to MAC weight_value.
- mac_output_value  in  2*DATA_WIDTH  from MAC output_value.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  2*DATA_WIDTH  finished dot product.
- busy  out  1  high when a partial sum is in progress (count != 0) or a result is pending.

Behaviour:
- Reset (rst_n low, asynchronous, any state):
  - state=ACCUM, acc=0, count=0.
  - out_valid=0, out_data=0, busy=0.
  - Takes effect immediately and aborts any partial sum or pending result.
- MAC drive (combinational):
  - mac_add_value=acc, mac_input_value=in_data, mac_weight_value=in_weight.
  - These ports are driven every cycle regardless of in_valid.
- States:
  - ACCUM: in_ready=1, out_valid=0.
  - DONE: in_ready=0, out_valid=1, out_data held stable until accepted.
- Accept = in_valid && in_ready.
- ACCUM, accept with count < VECTOR_LENGTH-1: acc<=mac_output_value, count<=count+1.
- ACCUM, accept with count == VECTOR_LENGTH-1:
  - out_data<=mac_output_value, acc<=0, count<=0, state<=DONE.
  - out_valid rises the following cycle, so result latency is 1 cycle after the final accept.
- DONE with out_ready=1: state<=ACCUM and out_valid drops next cycle. Minimum gap between the last pair of one vector and the first pair of the next is therefore 1 cycle.
- DONE with out_ready=0: hold indefinitely; out_data must not change.
- Arithmetic: unsigned, modulo 2^(2*DATA_WIDTH). Wrap-around is silent, with no saturation or overflow flag.
- VECTOR_LENGTH=1: every accept goes straight to DONE with out_data = in_data*in_weight.
- clear=1:
  - In ACCUM: acc<=0, count<=0; any same-cycle accept is ignored (clear wins).
  - In DONE: the pending result is dropped, out_valid<=0, state<=ACCUM.
- in_valid=1 while in DONE: not accepted. Upstream holds its data (standard valid/ready rule).
- X on in_data or in_weight while in_valid=0 must not corrupt acc.

Test Plan:
- Reset then VECTOR_LENGTH=4 with pairs (2,3),(5,2),(1,1),(255,255) back-to-back:
  - out_valid rises 1 cycle after the 4th accept with out_data=65042.
  - in_ready=0 while out_valid=1.
- VECTOR_LENGTH=2 with pairs (255,255),(255,255) -> out_data=64514 (130050 mod 65536, wrap).
- Backpressure: hold out_ready=0 for 5 cycles after a result while in_valid=1:
  - out_data stays stable; no pair is accepted.
  - Raising out_ready returns the block to ACCUM and the next vector starts from acc=0.
- Drive rst_n low asynchronously (mid-cycle) after 2 of 4 pairs:
  - busy, out_valid and acc clear immediately.
  - A following 4-pair vector of all (1,1) gives out_data=4.
- Assert clear after 3 pairs (3,3) together with a valid pair:
  - The pair is ignored and the partial sum is discarded.
  - The next 4-pair vector of (2,2) gives 16.
- VECTOR_LENGTH=1 with pairs (7,9) then (10,10) and out_ready=1 -> results 63 then 100, each 1 cycle after its accept.
